// File: rtl/alu_writeback_stage.sv
// rtl/alu_writeback_stage.sv - ALU result capture, NZCV update and in-order register write buffer
// Writes drain to the register file from the head; the youngest entry is exposed for forwarding.
module alu_writeback_stage #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 4,
  parameter int DEPTH   = 2,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_result,
  input  logic [3:0]         in_flags,
  input  logic [3:0]         in_opcode,
  input  logic               in_s,
  input  logic               in_cond_met,
  input  logic [RADDR_W-1:0] in_rd,
  output logic               wb_valid,
  input  logic               wb_ready,
  output logic [RADDR_W-1:0] wb_rd,
  output logic [DATA_W-1:0]  wb_data,
  output logic               fwd_valid,
  output logic [RADDR_W-1:0] fwd_rd,
  output logic [DATA_W-1:0]  fwd_data,
  output logic [3:0]         status_flags,
  output logic [CNT_W-1:0]   retire_cnt,
  output logic [CNT_W-1:0]   squash_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = PTR_W + 1;

  logic [RADDR_W-1:0] rd_mem_q   [DEPTH];
  logic [RADDR_W-1:0] rd_mem_d   [DEPTH];
  logic [DATA_W-1:0]  data_mem_q [DEPTH];
  logic [DATA_W-1:0]  data_mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, last_ptr;
  logic [CW-1:0]      count_q, count_d;
  logic [3:0]         flags_q, flags_d;
  logic [CNT_W-1:0]   retire_q, retire_d, squash_q, squash_d;

  logic accept, is_nop, is_arith, live, squash, push, pop, set_flags;

  assign in_ready = (count_q != CW'(DEPTH));
  assign wb_valid = (count_q != '0);
  assign fwd_valid = wb_valid;
  assign last_ptr = wr_ptr_q - PTR_W'(1);
  assign wb_rd    = wb_valid ? rd_mem_q[rd_ptr_q]   : '0;
  assign wb_data  = wb_valid ? data_mem_q[rd_ptr_q] : '0;
  assign fwd_rd   = wb_valid ? rd_mem_q[last_ptr]   : '0;
  assign fwd_data = wb_valid ? data_mem_q[last_ptr] : '0;
  assign status_flags = flags_q;
  assign retire_cnt   = retire_q;
  assign squash_cnt   = squash_q;

  // NOP outranks squash, which outranks every opcode-specific effect.
  always_comb begin
    accept    = in_valid && in_ready;
    is_nop    = (in_opcode == 4'b1111);
    is_arith  = (in_opcode <= 4'b0101);
    live      = accept && !is_nop && in_cond_met;
    squash    = accept && !is_nop && !in_cond_met;
    push      = live && (is_arith || in_opcode == 4'b0110 ||
                         in_opcode == 4'b0111 || in_opcode == 4'b1101);
    set_flags = live && ((in_opcode == 4'b1011) || (is_arith && in_s));
    pop       = wb_valid && wb_ready;
  end

  always_comb begin
    rd_mem_d   = rd_mem_q;
    data_mem_d = data_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    flags_d    = flags_q;
    retire_d   = retire_q;
    squash_d   = squash_q;
    if (push) begin
      rd_mem_d[wr_ptr_q]   = in_rd;
      data_mem_d[wr_ptr_q] = in_result;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
    if (set_flags) begin
      flags_d = in_flags;
    end
    if (pop && (retire_q != '1)) begin
      retire_d = retire_q + CNT_W'(1);
    end
    if (squash && (squash_q != '1)) begin
      squash_d = squash_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        rd_mem_q[i]   <= '0;
        data_mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      flags_q  <= 4'b0000;
      retire_q <= '0;
      squash_q <= '0;
    end else begin
      rd_mem_q   <= rd_mem_d;
      data_mem_q <= data_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      flags_q    <= flags_d;
      retire_q   <= retire_d;
      squash_q   <= squash_d;
    end
  end

endmodule

// File: tb/tb_alu_writeback_stage.sv
// tb/tb_alu_writeback_stage.sv - directed and randomized checks of alu_writeback_stage
// A queue-based model of the write buffer and status register supplies every expected value.
module tb_alu_writeback_stage;

  localparam int DATA_W = 32, RADDR_W = 4, DEPTH = 2, CNT_W = 16;

  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready, in_s = 0, in_cond_met = 1, wb_valid, wb_ready = 0, fwd_valid;
  logic [DATA_W-1:0] in_result = 0, wb_data, fwd_data;
  logic [3:0] in_flags = 0, in_opcode = 0, status_flags;
  logic [RADDR_W-1:0] in_rd = 0, wb_rd, fwd_rd;
  logic [CNT_W-1:0] retire_cnt, squash_cnt;

  alu_writeback_stage #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_flags(in_flags), .in_opcode(in_opcode), .in_s(in_s), .in_cond_met(in_cond_met),
    .in_rd(in_rd), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .status_flags(status_flags),
    .retire_cnt(retire_cnt), .squash_cnt(squash_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [RADDR_W-1:0] rd; logic [DATA_W-1:0] data; } wr_t;
  wr_t m_q[$];
  logic [3:0] m_flags;
  int m_ret, m_sq;
  int tests = 0, fails = 0;

  task automatic drive(input logic v, input logic [3:0] op, input logic s, input logic c,
                       input logic [3:0] f, input logic [RADDR_W-1:0] rd, input logic [DATA_W-1:0] r);
    in_valid = v; in_opcode = op; in_s = s; in_cond_met = c; in_flags = f; in_rd = rd; in_result = r;
  endtask

  task automatic model_clear();
    m_q.delete(); m_flags = 4'b0000; m_ret = 0; m_sq = 0;
  endtask

  // Advance one clock, updating the model from the inputs seen at that edge.
  task automatic tick();
    bit acc, pop, wr, fl;
    wr_t e;
    acc = in_valid && (m_q.size() != DEPTH);
    pop = (m_q.size() > 0) && wb_ready;
    wr = 0; fl = 0;
    if (acc && in_opcode != 4'd15) begin
      if (!in_cond_met) m_sq = (m_sq < 65535) ? m_sq + 1 : m_sq;
      else if (in_opcode == 4'd11) fl = 1;
      else if (in_opcode <= 4'd5) begin wr = 1; fl = in_s; end
      else if (in_opcode == 4'd6 || in_opcode == 4'd7 || in_opcode == 4'd13) wr = 1;
    end
    if (pop) begin void'(m_q.pop_front()); m_ret = (m_ret < 65535) ? m_ret + 1 : m_ret; end
    if (wr) begin e.rd = in_rd; e.data = in_result; m_q.push_back(e); end
    if (fl) m_flags = in_flags;
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst = 1; drive(0, 0, 0, 1, 0, 0, 0); wb_ready = 0;
    @(posedge clk); #1; rst = 0; model_clear();
  endtask

  task automatic test_reset();
    #1;
    tests++; if (wb_valid !== 1'b0) begin fails++; $display("FAIL reset_wb_valid got %b exp 0", wb_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    tests++; if ({fwd_valid, fwd_rd, fwd_data, wb_rd, wb_data} !== '0) begin fails++; $display("FAIL reset_outs got nonzero exp 0"); end
    tests++; if ({status_flags, retire_cnt, squash_cnt} !== '0) begin fails++; $display("FAIL reset_state got %h exp 0", {status_flags, retire_cnt, squash_cnt}); end
    @(posedge clk); #1; rst = 0; model_clear();
  endtask

  task automatic test_add();
    wb_ready = 1; drive(1, 4'b0000, 1, 1, 4'b0100, 3, 32'h5); tick(); in_valid = 0;
    tests++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 4'd3, 32'h5}) begin fails++; $display("FAIL add_wb got %b/%0d/%0h exp 1/3/5", wb_valid, wb_rd, wb_data); end
    tests++; if ({fwd_valid, fwd_rd} !== {1'b1, 4'd3}) begin fails++; $display("FAIL add_fwd got %b/%0d exp 1/3", fwd_valid, fwd_rd); end
    tests++; if (status_flags !== 4'b0100) begin fails++; $display("FAIL add_status got %b exp 0100", status_flags); end
    tick();
    tests++; if (wb_valid !== 1'b0 || retire_cnt !== 16'd1) begin fails++; $display("FAIL add_retire got %b/%0d exp 0/1", wb_valid, retire_cnt); end
  endtask

  task automatic test_flags();
    apply_reset(); wb_ready = 0;
    drive(1, 4'b1011, 0, 1, 4'b1000, 2, 32'h9); tick();
    tests++; if (status_flags !== 4'b1000 || wb_valid !== 1'b0) begin fails++; $display("FAIL cmp got %b/%b exp 1000/0", status_flags, wb_valid); end
    drive(1, 4'b0010, 0, 1, 4'b0001, 6, 32'h77); tick(); in_valid = 0;
    tests++; if (status_flags !== 4'b1000) begin fails++; $display("FAIL add_nos_status got %b exp 1000", status_flags); end
    tests++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 4'd6, 32'h77}) begin fails++; $display("FAIL add_nos_push got %b/%0d/%0h exp 1/6/77", wb_valid, wb_rd, wb_data); end
  endtask

  task automatic test_backpressure();
    logic [RADDR_W-1:0] seen[$];
    apply_reset(); wb_ready = 0;
    drive(1, 4'b0000, 0, 1, 0, 1, 32'h11); tick();
    drive(1, 4'b0001, 0, 1, 0, 2, 32'h22); tick();
    tests++; if (in_ready !== 1'b0 || fwd_rd !== 4'd2) begin fails++; $display("FAIL bp_full got %b/%0d exp 0/2", in_ready, fwd_rd); end
    drive(1, 4'b0000, 0, 1, 0, 4, 32'h44); tick();
    tests++; if (in_ready !== 1'b0 || wb_rd !== 4'd1 || fwd_rd !== 4'd2) begin fails++; $display("FAIL bp_held got %b/%0d/%0d exp 0/1/2", in_ready, wb_rd, fwd_rd); end
    wb_ready = 1;
    for (int i = 0; i < 8 && seen.size() < 3; i++) begin
      if (wb_valid) seen.push_back(wb_rd);
      if (in_valid && in_ready) begin tick(); in_valid = 0; end else tick();
    end
    tests++; if (seen.size() != 3 || seen[0] !== 4'd1 || seen[1] !== 4'd2 || seen[2] !== 4'd4) begin fails++; $display("FAIL bp_order got %0d entries exp 1,2,4", seen.size()); end
    tick();
    tests++; if (retire_cnt !== 16'd3 || wb_valid !== 1'b0) begin fails++; $display("FAIL bp_retire got %0d/%b exp 3/0", retire_cnt, wb_valid); end
  endtask

  task automatic test_squash_nop();
    apply_reset(); wb_ready = 0;
    drive(1, 4'b0000, 1, 0, 4'b1111, 5, 32'h1); tick();
    tests++; if (wb_valid !== 1'b0 || status_flags !== 4'b0000 || squash_cnt !== 16'd1) begin fails++; $display("FAIL squash got %b/%b/%0d exp 0/0000/1", wb_valid, status_flags, squash_cnt); end
    drive(1, 4'b1111, 1, 1, 4'b1111, 5, 32'h1); tick();
    tests++; if (wb_valid !== 1'b0 || status_flags !== 4'b0000 || squash_cnt !== 16'd1) begin fails++; $display("FAIL nop got %b/%b/%0d exp 0/0000/1", wb_valid, status_flags, squash_cnt); end
    drive(1, 4'b1110, 1, 1, 4'b1111, 5, 32'h1); tick(); in_valid = 0;
    tests++; if (wb_valid !== 1'b0 || status_flags !== 4'b0000) begin fails++; $display("FAIL store got %b/%b exp 0/0000", wb_valid, status_flags); end
  endtask

  task automatic test_concurrent();
    apply_reset(); wb_ready = 0;
    drive(1, 4'b0011, 0, 1, 0, 5, 32'h55); tick();
    wb_ready = 1; drive(1, 4'b0100, 0, 1, 0, 6, 32'h66); tick(); in_valid = 0;
    tests++; if ({wb_valid, wb_rd, wb_data, fwd_rd, in_ready} !== {1'b1, 4'd6, 32'h66, 4'd6, 1'b1}) begin fails++; $display("FAIL conc got %b/%0d/%0h exp 1/6/66", wb_valid, wb_rd, wb_data); end
    tests++; if (retire_cnt !== 16'd1) begin fails++; $display("FAIL conc_retire got %0d exp 1", retire_cnt); end
    tick();
    tests++; if (wb_valid !== 1'b0 || retire_cnt !== 16'd2) begin fails++; $display("FAIL conc_drain got %b/%0d exp 0/2", wb_valid, retire_cnt); end
  endtask

  task automatic test_reset_mid();
    apply_reset(); wb_ready = 0;
    drive(1, 4'b0000, 1, 1, 4'b1010, 7, 32'h70); tick();
    drive(1, 4'b0000, 0, 1, 4'b0000, 8, 32'h80); tick(); in_valid = 0;
    tests++; if (in_ready !== 1'b0 || status_flags !== 4'b1010) begin fails++; $display("FAIL mid_pre got %b/%b exp 0/1010", in_ready, status_flags); end
    rst = 1; #1;
    tests++; if ({wb_valid, fwd_valid, in_ready, status_flags} !== {1'b0, 1'b0, 1'b1, 4'b0000}) begin fails++; $display("FAIL mid_rst got %b%b%b/%b exp 001/0000", wb_valid, fwd_valid, in_ready, status_flags); end
    tests++; if (retire_cnt !== 16'd0 || squash_cnt !== 16'd0) begin fails++; $display("FAIL mid_cnt got %0d/%0d exp 0/0", retire_cnt, squash_cnt); end
    rst = 0; model_clear(); @(posedge clk); #1;
    wb_ready = 1; drive(1, 4'b0101, 0, 1, 0, 9, 32'h99); tick(); in_valid = 0;
    tests++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 4'd9, 32'h99}) begin fails++; $display("FAIL post_rst got %b/%0d/%0h exp 1/9/99", wb_valid, wb_rd, wb_data); end
    tick();
    tests++; if (retire_cnt !== 16'd1) begin fails++; $display("FAIL post_retire got %0d exp 1", retire_cnt); end
  endtask

  task automatic test_random();
    logic [RADDR_W-1:0] e_rd, e_frd;
    logic [DATA_W-1:0] e_d, e_fd;
    int bad;
    apply_reset();
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), 1'($urandom), $urandom_range(0, 5) != 0,
            4'($urandom), 4'($urandom), $urandom);
      wb_ready = $urandom_range(0, 2) != 0;
      tick();
      e_rd  = m_q.size() ? m_q[0].rd : '0;
      e_d   = m_q.size() ? m_q[0].data : '0;
      e_frd = m_q.size() ? m_q[m_q.size()-1].rd : '0;
      e_fd  = m_q.size() ? m_q[m_q.size()-1].data : '0;
      tests++;
      if ({wb_valid, wb_rd, wb_data, fwd_valid, fwd_rd, fwd_data, in_ready} !==
          {m_q.size() != 0, e_rd, e_d, m_q.size() != 0, e_frd, e_fd, m_q.size() != DEPTH}) begin
        fails++; bad++;
        if (bad < 5) $display("FAIL rand_fifo cyc %0d got %b/%0d/%0h fwd %0d exp %b/%0d/%0h fwd %0d", i, wb_valid, wb_rd, wb_data, fwd_rd, m_q.size() != 0, e_rd, e_d, e_frd);
      end
      tests++;
      if (status_flags !== m_flags || retire_cnt !== CNT_W'(m_ret) || squash_cnt !== CNT_W'(m_sq)) begin
        fails++; bad++;
        if (bad < 5) $display("FAIL rand_state cyc %0d got %b/%0d/%0d exp %b/%0d/%0d", i, status_flags, retire_cnt, squash_cnt, m_flags, m_ret, m_sq);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_flags();
    test_backpressure();
    test_squash_nop();
    test_concurrent();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
